// File: rtl/gaussian_coef_gen.sv
// rtl/gaussian_coef_gen.sv - runtime-configurable Gaussian coefficient generator
//
// Builds the unique taps g[0..H] of a separable Gaussian with an integer multiply
// recurrence (g[d] ~ r^(d^2)), normalises them to Q2.FRAC with a restoring divider,
// then streams the 1-D taps or the 2-D outer product over a valid/ready port.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, abort          run request (IDLE only) / cancel current run
//   cfg_size, cfg_r,      kernel edge N, r = exp(-1/(2 sigma^2)) in Q0.R_W,
//   cfg_mode              0 = 1-D (N beats), 1 = 2-D (N*N beats); sampled at accept
//   busy, err, done       run in progress / illegal-size pulse / end-of-run pulse
//   out_valid, out_ready, coefficient stream
//   out_data, out_last
module gaussian_coef_gen #(
   parameter int MAX_SIZE = 9,
   parameter int FRAC     = 14,
   parameter int COEF_W   = 16,
   parameter int R_W      = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [3:0]        cfg_size,
   input  logic [R_W-1:0]    cfg_r,
   input  logic              cfg_mode,
   output logic              busy,
   output logic              err,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [COEF_W-1:0] out_data,
   output logic              out_last,
   output logic              done
);

   localparam int MAX_H = (MAX_SIZE - 1) / 2;
   localparam int IDX_W = $clog2(MAX_H + 1);
   localparam int G_W   = R_W + 1;
   localparam int S_W   = R_W + 1 + $clog2(MAX_SIZE);
   localparam int C_W   = FRAC + 1;
   localparam int DIV_W = S_W + C_W;
   localparam int BIT_W = $clog2(C_W + 1);
   localparam int GP_W  = G_W + R_W;
   localparam int RP_W  = 2 * R_W;
   localparam int P_W   = 2 * C_W;

   localparam logic [GP_W-1:0]  GP_HALF  = GP_W'(1) << (R_W - 1);
   localparam logic [RP_W-1:0]  RP_HALF  = RP_W'(1) << (R_W - 1);
   localparam logic [P_W-1:0]   P_HALF   = P_W'(1) << (FRAC - 1);
   localparam logic [P_W-1:0]   P_SAT    = P_W'({COEF_W{1'b1}});
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(C_W);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [3:0]       SIZE_MAX = 4'(MAX_SIZE);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_GEN, S_SUM, S_NORM, S_EMIT} state_t;

   state_t             r_state, w_next;
   logic [3:0]         r_n;
   logic [IDX_W-1:0]   r_h, r_d, r_tap;
   logic [R_W-1:0]     r_r, r_q, r_r2;
   logic               r_mode;
   logic [G_W-1:0]     r_g [0:MAX_H];
   logic [C_W-1:0]     r_c [0:MAX_H];
   logic [S_W-1:0]     r_s, r_rem;
   logic [C_W-1:0]     r_quo;
   logic [BIT_W-1:0]   r_bit;
   logic [3:0]         r_i, r_j;
   logic               r_err, r_done;

   logic               w_size_ok, w_xfer, w_last;
   logic [RP_W-1:0]    w_r2_prod, w_q_prod;
   logic [R_W-1:0]     w_r2, w_q_next;
   logic [GP_W-1:0]    w_g_prod;
   logic [G_W-1:0]     w_g_next;
   logic [S_W-1:0]     w_sum, w_rem_next;
   logic [DIV_W-1:0]   w_dividend;
   logic [S_W:0]       w_trial;
   logic               w_ge;
   logic [C_W-1:0]     w_quo_next, w_ca, w_cb;
   logic [3:0]         w_hn, w_di_full, w_dj_full, w_n_m1;
   logic [IDX_W-1:0]   w_di, w_dj;
   logic [P_W-1:0]     w_prod, w_prod_sh;
   logic [COEF_W-1:0]  w_coef2;

   assign w_size_ok = cfg_size[0] && (cfg_size >= 4'd3) && (cfg_size <= SIZE_MAX);

   // Recurrence arithmetic, each product rounded half-up before the shift.
   assign w_r2_prod = RP_W'(r_r) * RP_W'(r_r);
   assign w_r2      = R_W'((w_r2_prod + RP_HALF) >> R_W);
   assign w_g_prod  = GP_W'(r_g[r_d - IDX_ONE]) * GP_W'(r_q);
   assign w_g_next  = G_W'((w_g_prod + GP_HALF) >> R_W);
   assign w_q_prod  = RP_W'(r_q) * RP_W'(r_r2);
   assign w_q_next  = R_W'((w_q_prod + RP_HALF) >> R_W);

   // Unused high taps stay zero (cleared in PREP), so summing the full array is safe.
   always_comb begin
      w_sum = S_W'(r_g[0]);
      for (int k = 1; k <= MAX_H; k++) begin
         w_sum = w_sum + (S_W'(r_g[k]) << 1);
      end
   end

   // Restoring divider: the quotient never exceeds 2^FRAC, so the upper dividend
   // bits are already below S and C_W iterations produce the whole quotient.
   assign w_dividend = (DIV_W'(r_g[r_tap]) << FRAC) + DIV_W'(r_s >> 1);
   assign w_trial    = {r_rem, r_quo[C_W-1]};
   assign w_ge       = (w_trial >= {1'b0, r_s});
   assign w_rem_next = w_ge ? S_W'(w_trial - {1'b0, r_s}) : S_W'(w_trial);
   assign w_quo_next = {r_quo[C_W-2:0], w_ge};

   // Beat (i,j) uses the mirrored tap distance from the centre on each axis.
   assign w_hn      = 4'(r_h);
   assign w_n_m1    = r_n - 4'd1;
   assign w_di_full = (r_i >= w_hn) ? (r_i - w_hn) : (w_hn - r_i);
   assign w_dj_full = (r_j >= w_hn) ? (r_j - w_hn) : (w_hn - r_j);
   assign w_di      = IDX_W'(w_di_full);
   assign w_dj      = IDX_W'(w_dj_full);
   assign w_ca      = r_c[w_di];
   assign w_cb      = r_c[w_dj];
   assign w_prod    = P_W'(w_ca) * P_W'(w_cb) + P_HALF;
   assign w_prod_sh = w_prod >> FRAC;
   assign w_coef2   = (w_prod_sh > P_SAT) ? {COEF_W{1'b1}} : COEF_W'(w_prod_sh);

   assign w_last = r_mode ? ((r_i == w_n_m1) && (r_j == w_n_m1)) : (r_j == w_n_m1);
   assign w_xfer = (r_state == S_EMIT) && out_ready;

   assign busy      = (r_state != S_IDLE);
   assign out_valid = (r_state == S_EMIT);
   assign out_last  = out_valid && w_last;
   assign out_data  = out_valid ? (r_mode ? w_coef2 : COEF_W'(w_cb)) : '0;
   assign err       = r_err;
   assign done      = r_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start && w_size_ok) w_next = S_PREP;
         S_PREP:  w_next = S_GEN;
         S_GEN:   if (r_d == r_h) w_next = S_SUM;
         S_SUM:   w_next = S_NORM;
         S_NORM:  if ((r_tap == r_h) && (r_bit == BIT_LAST)) w_next = S_EMIT;
         S_EMIT:  if (w_xfer && w_last) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      // abort beats everything, including a transfer in the same cycle
      if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_n    <= '0;
         r_h    <= '0;
         r_d    <= '0;
         r_tap  <= '0;
         r_r    <= '0;
         r_q    <= '0;
         r_r2   <= '0;
         r_mode <= 1'b0;
         r_s    <= '0;
         r_rem  <= '0;
         r_quo  <= '0;
         r_bit  <= '0;
         r_i    <= '0;
         r_j    <= '0;
         r_err  <= 1'b0;
         r_done <= 1'b0;
         for (int k = 0; k <= MAX_H; k++) begin
            r_g[k] <= '0;
            r_c[k] <= '0;
         end
      end else begin
         r_err  <= (r_state == S_IDLE) && start && !w_size_ok;
         r_done <= w_xfer && w_last && !abort;
         case (r_state)
            S_IDLE: begin
               if (start && w_size_ok) begin
                  r_n    <= cfg_size;
                  r_h    <= IDX_W'((cfg_size - 4'd1) >> 1);
                  r_r    <= cfg_r;
                  r_mode <= cfg_mode;
                  r_i    <= '0;
                  r_j    <= '0;
               end
            end
            S_PREP: begin
               for (int k = 1; k <= MAX_H; k++) begin
                  r_g[k] <= '0;
               end
               r_g[0] <= G_W'(1) << R_W;
               r_q    <= r_r;
               r_r2   <= w_r2;
               r_d    <= IDX_ONE;
            end
            S_GEN: begin
               r_g[r_d] <= w_g_next;
               r_q      <= w_q_next;
               r_d      <= r_d + IDX_ONE;
            end
            S_SUM: begin
               r_s   <= w_sum;
               r_tap <= '0;
               r_bit <= '0;
            end
            S_NORM: begin
               if (r_bit == '0) begin
                  r_rem <= w_dividend[DIV_W-1:C_W];
                  r_quo <= w_dividend[C_W-1:0];
                  r_bit <= BIT_ONE;
               end else begin
                  r_rem <= w_rem_next;
                  r_quo <= w_quo_next;
                  if (r_bit == BIT_LAST) begin
                     r_c[r_tap] <= w_quo_next;
                     r_tap      <= r_tap + IDX_ONE;
                     r_bit      <= '0;
                  end else begin
                     r_bit <= r_bit + BIT_ONE;
                  end
               end
            end
            S_EMIT: begin
               if (w_xfer) begin
                  if (r_j == w_n_m1) begin
                     r_j <= '0;
                     r_i <= r_i + 4'd1;
                  end else begin
                     r_j <= r_j + 4'd1;
                  end
               end
            end
            default: begin
               r_d <= '0;
            end
         endcase
      end
   end

endmodule
